dmem_cache_ctrl: RTL

//  Responder side of the data-memory request protocol used by the MEM stage (Rd/Wr/Addr/DataIn -> Done/Stall/CacheHit/DataOut/err).

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_tag_array.sv | 45 ++++
 rtl/dmem_cache_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory cache controller: FSM encodings, default
// geometry and the address-field width helpers.
package dmem_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int DEF_IDX_W   = 3;
  localparam int DEF_MEM_LAT = 4;
  localparam int DEF_MEM_AW  = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte address = {tag, index, byte-select}.
  function automatic int tag_w(input int idx_w);
    return ADDR_W - idx_w - 1;
  endfunction

endpackage

// File: rtl/dmem_tag_array.sv
// Direct-mapped line store: async-cleared valid bits, unreset tag/data,
// combinational lookup and a single synchronous write port.
module dmem_tag_array
  import dmem_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        rd_idx_i,
  input  logic [tag_w(IDX_W)-1:0] rd_tag_i,
  output logic                    rd_hit_o,
  output logic [DATA_W-1:0]       rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [tag_w(IDX_W)-1:0] wr_tag_i,
  input  logic [DATA_W-1:0]       wr_data_i
);

  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = tag_w(IDX_W);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Write-through, no-write-allocate direct-mapped cache in front of a fixed-latency
// backing memory; one request in flight, one-cycle Done. Optional dump: DMEM_DUMP_EN.
module dmem_cache_ctrl
  import dmem_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int MEM_AW  = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  input  logic              createdump,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err
);

  localparam int TAG_W = tag_w(IDX_W);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:1] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              wr_q, hit_q;
  logic              done_q, done_d, err_q, err_d, chit_q, chit_d, stall_q, stall_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [DATA_W-1:0] mem_rdata;
  logic              accept, bad_req, last_wait, line_we, mem_we;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;

  assign accept    = (state_q == ST_IDLE) && (Rd || Wr);
  assign bad_req   = (Rd && Wr) || Addr[0];
  assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_rdata = mem_q[addr_q[MEM_AW:1]];
  // Reads fill on miss; writes only update a line that was resident at accept.
  assign line_we   = last_wait && (!wr_q || hit_q);
  assign mem_we    = last_wait && wr_q;

  dmem_tag_array #(.IDX_W(IDX_W)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (Addr[IDX_W:1]),
    .rd_tag_i  (Addr[ADDR_W-1:IDX_W+1]),
    .rd_hit_o  (lk_hit),
    .rd_data_o (lk_data),
    .wr_en_i   (line_we),
    .wr_idx_i  (addr_q[IDX_W:1]),
    .wr_tag_i  (addr_q[ADDR_W-1:IDX_W+1]),
    .wr_data_i (wr_q ? din_q : mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q[MEM_AW:1]] <= din_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    chit_d  = 1'b0;
    stall_d = 1'b0;
    dout_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (Rd || Wr) begin
          if (bad_req) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (Rd && lk_hit) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            chit_d  = 1'b1;
            dout_d  = lk_data;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
            stall_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          chit_d  = hit_q;
          dout_d  = wr_q ? '0 : mem_rdata;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      chit_q  <= 1'b0;
      stall_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      chit_q  <= chit_d;
      stall_q <= stall_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      hit_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= Addr[ADDR_W-1:1];
      din_q  <= DataIn;
      wr_q   <= Wr;
      hit_q  <= lk_hit;
    end
  end

  assign DataOut  = dout_q;
  assign Done     = done_q;
  assign Stall    = stall_q;
  assign CacheHit = chit_q;
  assign err      = err_q;

`ifdef DMEM_DUMP_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else if (accept && !bad_req) begin
      if (Wr) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 1'b1;
      end else if (lk_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && (state_q == ST_IDLE) && createdump) begin
      $display("dmem dump: hits=%0d misses=%0d writes=%0d", hit_cnt_q, miss_cnt_q, wr_cnt_q);
      for (int i = 0; i < 2 ** IDX_W; i++) begin
        if (u_tags.valid_q[i]) begin
          $display("  line %0d tag=%h data=%h", i, u_tags.tag_q[i], u_tags.data_q[i]);
        end
      end
    end
  end
`else
  logic unused_createdump;
  assign unused_createdump = createdump;
`endif

endmodule
